// File: rtl/truth_table_checker.sv
// Response-side checker for exhaustive truth-table tests: tracks coverage, mismatches and the first failing vector.
// Optional MISR over accepted pairs is built when SIGNATURE_EN is defined; otherwise signature reads 0.
module truth_table_checker #(
    parameter int                      N_IN   = 3,
    parameter logic [(1<<N_IN)-1:0]    EXPECT = 8'hE8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    vec_valid,
    output logic                    vec_ready,
    input  logic [N_IN-1:0]         vec_in,
    input  logic                    resp_in,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [N_IN:0]           err_count,
    output logic [N_IN-1:0]         first_err_vec,
    output logic                    first_err_valid,
    output logic [(1<<N_IN)-1:0]    coverage,
    output logic [15:0]             signature
);
    localparam int NV = 1 << N_IN;

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t            state_q, state_d;
    logic [N_IN:0]     err_q, err_d;
    logic [N_IN-1:0]   fvec_q, fvec_d;
    logic              fvld_q, fvld_d;
    logic [NV-1:0]     cov_q, cov_d;
    logic              accept, clr, mismatch;

    // start only re-arms from IDLE or DONE; in COLLECT it is ignored
    assign clr      = (state_q != COLLECT) && start;
    assign accept   = (state_q == COLLECT) && vec_valid;
    assign mismatch = resp_in ^ EXPECT[vec_in];

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        fvec_d  = fvec_q;
        fvld_d  = fvld_q;
        cov_d   = cov_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = COLLECT;
                    err_d   = '0;
                    fvec_d  = '0;
                    fvld_d  = 1'b0;
                    cov_d   = '0;
                end
            end
            COLLECT: begin
                // completion is seen from the registered coverage, so DONE lands one edge later
                if (&cov_q) state_d = DONE;
                if (accept) begin
                    cov_d[vec_in] = 1'b1;
                    if (mismatch) begin
                        if (err_q != '1) err_d = err_q + 1'b1;
                        if (!fvld_q) begin
                            fvec_d = vec_in;
                            fvld_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            err_q   <= '0;
            fvec_q  <= '0;
            fvld_q  <= 1'b0;
            cov_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            fvec_q  <= fvec_d;
            fvld_q  <= fvld_d;
            cov_q   <= cov_d;
        end
    end

`ifdef SIGNATURE_EN
    logic [15:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (accept) begin
            sig_d = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000)
                  ^ {{(15-N_IN){1'b0}}, vec_in, resp_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= '0;
        else        sig_q <= sig_d;
    end

    assign signature = sig_q;
`else
    assign signature = 16'h0000;
`endif

    assign vec_ready       = (state_q == COLLECT);
    assign busy            = (state_q == COLLECT);
    assign done            = (state_q == DONE);
    assign pass            = done && (err_q == '0);
    assign err_count       = err_q;
    assign first_err_vec   = fvec_q;
    assign first_err_valid = fvld_q;
    assign coverage        = cov_q;
endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench for truth_table_checker: directed table, hand sequences and random runs vs. a simple model.
module tb_truth_table_checker;
    localparam logic [7:0] EXP = 8'hE8;

    logic        clk = 1'b0;
    logic        rst_n, start, vec_valid, resp_in;
    logic [2:0]  vec_in;
    logic        vec_ready, busy, done, pass, first_err_valid;
    logic [3:0]  err_count;
    logic [2:0]  first_err_vec;
    logic [7:0]  coverage;
    logic [15:0] signature;

    int checks = 0;
    int errors = 0;

    truth_table_checker #(.N_IN(3), .EXPECT(8'hE8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid),
        .vec_ready(vec_ready), .vec_in(vec_in), .resp_in(resp_in),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_vec(first_err_vec), .first_err_valid(first_err_valid),
        .coverage(coverage), .signature(signature)
    );

    always #5 clk = ~clk;

    // reference model: set of seen vectors, raw mismatch count, first failing vector
    bit seen [8];
    int nerr;
    int first;

    typedef struct {
        logic [2:0] vec;
        bit         flip;
        int         exp_err;
        logic [7:0] exp_cov;
    } vec_rec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit exp_bit(input int v);
        return bit'((EXP >> v) & 8'h1);
    endfunction

    function automatic logic [7:0] m_cov();
        logic [7:0] c = 8'h0;
        for (int i = 0; i < 8; i++) if (seen[i]) c = c | (8'h1 << i);
        return c;
    endfunction

    function automatic int m_err();
        return (nerr > 15) ? 15 : nerr;
    endfunction

    function automatic bit m_full();
        return m_cov() == 8'hFF;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 8; i++) seen[i] = 1'b0;
        nerr  = 0;
        first = -1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_cov"}, 32'(coverage), 32'(m_cov()));
        chk({tag, "_err"}, 32'(err_count), 32'(m_err()));
        chk({tag, "_fvld"}, 32'(first_err_valid), (first >= 0) ? 32'd1 : 32'd0);
        if (first >= 0) chk({tag, "_fvec"}, 32'(first_err_vec), 32'(first));
    endtask

    // called at a negedge; leaves at the following negedge
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        m_clear();
    endtask

    task automatic send(input logic [2:0] v, input bit flip);
        chk("send_ready", 32'(vec_ready), 32'd1);
        vec_valid = 1'b1;
        vec_in    = v;
        resp_in   = exp_bit(int'(v)) ^ flip;
        @(posedge clk);
        seen[v] = 1'b1;
        if (flip) begin
            nerr++;
            if (first < 0) first = int'(v);
        end
        @(negedge clk);
        vec_valid = 1'b0;
    endtask

    task automatic finish_run(input string tag);
        chk({tag, "_pre_done"}, 32'(done), 32'd0);
        chk({tag, "_pre_busy"}, 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_pass"}, 32'(pass), (nerr == 0) ? 32'd1 : 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(vec_ready), 32'd0);
        check_model(tag);
    endtask

    task automatic run_inorder(input int flip_vec);
        pulse_start();
        for (int i = 0; i < 8; i++) send(3'(i), i == flip_vec);
    endtask

    initial begin
        vec_rec_t tbl [9];
        logic [15:0] sig_ref;
        int guard;

        tbl[0] = '{3'd7, 1'b0, 0, 8'h80};
        tbl[1] = '{3'd3, 1'b0, 0, 8'h88};
        tbl[2] = '{3'd3, 1'b1, 1, 8'h88};
        tbl[3] = '{3'd0, 1'b0, 1, 8'h89};
        tbl[4] = '{3'd1, 1'b0, 1, 8'h8B};
        tbl[5] = '{3'd2, 1'b0, 1, 8'h8F};
        tbl[6] = '{3'd4, 1'b0, 1, 8'h9F};
        tbl[7] = '{3'd5, 1'b0, 1, 8'hBF};
        tbl[8] = '{3'd6, 1'b0, 1, 8'hFF};

        rst_n = 1'b0; start = 1'b0; vec_valid = 1'b0; vec_in = '0; resp_in = 1'b0;
        m_clear();
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(vec_ready), 32'd0);
        chk("rst_cov", 32'(coverage), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_sig", 32'(signature), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // vec_valid in IDLE has no effect
        for (int i = 0; i < 5; i++) begin
            vec_valid = 1'b1;
            vec_in    = 3'($urandom_range(7));
            resp_in   = 1'($urandom_range(1));
            @(posedge clk);
            @(negedge clk);
            chk("idle_ready", 32'(vec_ready), 32'd0);
            chk("idle_cov", 32'(coverage), 32'd0);
            chk("idle_err", 32'(err_count), 32'd0);
        end
        vec_valid = 1'b0;

        // scenario 1: clean in-order run
        run_inorder(-1);
        check_model("s1");
        finish_run("s1");
        sig_ref = signature;
        run_inorder(-1);
        finish_run("s1b");
`ifdef SIGNATURE_EN
        chk("sig_repeat", 32'(signature), 32'(sig_ref));
`else
        chk("sig_zero", 32'(signature), 32'd0);
`endif

        // scenario 5: restart from DONE clears everything
        pulse_start();
        chk("rs_busy", 32'(busy), 32'd1);
        chk("rs_ready", 32'(vec_ready), 32'd1);
        check_model("rs");
        for (int i = 0; i < 8; i++) send(3'(i), 1'b0);
        finish_run("rs");

        // scenario 2: vector 5 wrong
        run_inorder(5);
        finish_run("s2");
`ifdef SIGNATURE_EN
        checks++;
        if (signature === sig_ref) begin
            errors++;
            $display("FAIL sig_flip: got %0h, must differ from %0h", signature, sig_ref);
        end
`else
        chk("sig_zero2", 32'(signature), 32'd0);
`endif

        // scenario 3: out-of-order with a duplicate, table-driven
        pulse_start();
        for (int i = 0; i < 9; i++) begin
            send(tbl[i].vec, tbl[i].flip);
            chk("tbl_err", 32'(err_count), 32'(tbl[i].exp_err));
            chk("tbl_cov", 32'(coverage), 32'(tbl[i].exp_cov));
            if (i < 8) chk("tbl_done", 32'(done), 32'd0);
        end
        finish_run("s3");
        chk("s3_fvec", 32'(first_err_vec), 32'd3);

        pulse_start();
        for (int i = 0; i < 9; i++) send(tbl[i].vec, tbl[i].vec == 3'd3);
        finish_run("s3b");
        chk("s3b_err", 32'(err_count), 32'd2);

        // saturation: repeated wrong vector 0, then the rest
        pulse_start();
        for (int i = 0; i < 18; i++) send(3'd0, 1'b1);
        chk("sat_err", 32'(err_count), 32'd15);
        for (int i = 1; i < 8; i++) send(3'(i), 1'b0);
        finish_run("sat");

        // start coincident with a handshake is ignored
        pulse_start();
        start = 1'b1;
        send(3'd2, 1'b1);
        start = 1'b0;
        check_model("st_hs");
        for (int i = 0; i < 8; i++) if (i != 2) send(3'(i), 1'b0);
        finish_run("st_hs");

        // random runs against the model
        for (int r = 0; r < 6; r++) begin
            pulse_start();
            guard = 0;
            while (!m_full() && guard < 300) begin
                guard++;
                if ($urandom_range(3) == 0) begin
                    @(posedge clk);
                    @(negedge clk);
                end else begin
                    send(3'($urandom_range(7)), $urandom_range(4) == 0);
                end
                check_model("rnd");
            end
            chk("rnd_guard", 32'(m_full()), 32'd1);
            finish_run("rnd");
        end

        // scenario 4: reset mid-run
        pulse_start();
        for (int i = 0; i < 4; i++) send(3'(i), i == 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ready", 32'(vec_ready), 32'd0);
        chk("mrst_cov", 32'(coverage), 32'd0);
        chk("mrst_err", 32'(err_count), 32'd0);
        chk("mrst_fvld", 32'(first_err_valid), 32'd0);
        chk("mrst_fvec", 32'(first_err_vec), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_pass", 32'(pass), 32'd0);
        chk("mrst_sig", 32'(signature), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
